// File: rtl/sap_control_sequencer.sv
// Control sequencer for the 8-bit bus computer: a 5-step T-counter whose
// outputs are a combinational decode of step, opcode and flags, gated by step_en, halt and reset.
module sap_control_sequencer #(
  parameter int         STEP_W     = 3,
  parameter logic [3:0] HLT_OPCODE = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_en,
  input  logic [3:0] opcode,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic [7:0] n_load,
  output logic [4:0] bus_oe,
  output logic       pc_inc,
  output logic       alu_sub,
  output logic       halted
);

  typedef enum logic [STEP_W-1:0] {
    T1 = STEP_W'(0),
    T2 = STEP_W'(1),
    T3 = STEP_W'(2),
    T4 = STEP_W'(3),
    T5 = STEP_W'(4)
  } step_e;

  localparam int LD_MAR = 0, LD_IR = 1, LD_A = 2, LD_B = 3;
  localparam int LD_OUT = 4, LD_RAM = 5, LD_FLG = 6, LD_PC = 7;
  localparam int OE_PC = 0, OE_RAM = 1, OE_IRL = 2, OE_A = 3, OE_ALU = 4;

  step_e      step_q, step_d;
  logic       halted_q, halted_d;
  logic [7:0] ld_vec;
  logic [4:0] oe_vec;
  logic       inc;
  logic       sub;
  logic       active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q   <= T1;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // rst is in the gate so outputs drop the instant reset rises, not at the next edge.
  assign active = step_en & ~halted_q & ~rst;

  always_comb begin
    ld_vec   = '0;
    oe_vec   = '0;
    inc      = 1'b0;
    sub      = 1'b0;
    step_d   = T1;
    halted_d = halted_q;
    case (step_q)
      T1: begin
        oe_vec[OE_PC]  = 1'b1;
        ld_vec[LD_MAR] = 1'b1;
        step_d         = T2;
      end
      T2: begin
        oe_vec[OE_RAM] = 1'b1;
        ld_vec[LD_IR]  = 1'b1;
        inc            = 1'b1;
        step_d         = T3;
      end
      T3: begin
        if (opcode == HLT_OPCODE) begin
          halted_d = 1'b1;
        end else begin
          case (opcode)
            4'h0, 4'h1, 4'h2, 4'h4: begin
              oe_vec[OE_IRL] = 1'b1;
              ld_vec[LD_MAR] = 1'b1;
              step_d         = T4;
            end
            4'h5: begin
              oe_vec[OE_IRL] = 1'b1;
              ld_vec[LD_A]   = 1'b1;
            end
            4'h6: begin
              oe_vec[OE_IRL] = 1'b1;
              ld_vec[LD_PC]  = 1'b1;
            end
            4'h7: begin
              oe_vec[OE_IRL] = 1'b1;
              ld_vec[LD_PC]  = flag_c;
            end
            4'h8: begin
              oe_vec[OE_IRL] = 1'b1;
              ld_vec[LD_PC]  = flag_z;
            end
            4'hE: begin
              oe_vec[OE_A]   = 1'b1;
              ld_vec[LD_OUT] = 1'b1;
            end
            default: ;
          endcase
        end
      end
      T4: begin
        case (opcode)
          4'h0: begin
            oe_vec[OE_RAM] = 1'b1;
            ld_vec[LD_A]   = 1'b1;
          end
          4'h1, 4'h2: begin
            oe_vec[OE_RAM] = 1'b1;
            ld_vec[LD_B]   = 1'b1;
            step_d         = T5;
          end
          4'h4: begin
            oe_vec[OE_A]   = 1'b1;
            ld_vec[LD_RAM] = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        if (opcode == 4'h1 || opcode == 4'h2) begin
          oe_vec[OE_ALU] = 1'b1;
          ld_vec[LD_A]   = 1'b1;
          ld_vec[LD_FLG] = 1'b1;
          sub            = (opcode == 4'h2);
        end
      end
      default: ;
    endcase

    if (!active) begin
      step_d   = step_q;
      halted_d = halted_q;
    end
  end

  assign n_load  = active ? ~ld_vec : 8'hFF;
  assign bus_oe  = active ? oe_vec : 5'h00;
  assign pc_inc  = active & inc;
  assign alu_sub = active & sub;
  assign halted  = halted_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: per-instruction expected cycle lists built
// from the microcode table, driven with random opcodes, flags and stalls.
module tb_sap_control_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       step_en;
  logic [3:0] opcode;
  logic       flag_c;
  logic       flag_z;
  logic [7:0] n_load;
  logic [4:0] bus_oe;
  logic       pc_inc;
  logic       alu_sub;
  logic       halted;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [4:0] oe;
    logic [7:0] ld;
    logic       inc;
    logic       sub;
  } cyc_t;

  cyc_t exp_q[$];

  sap_control_sequencer #(.STEP_W(3), .HLT_OPCODE(4'hF)) dut (
    .clk     (clk),
    .rst     (rst),
    .step_en (step_en),
    .opcode  (opcode),
    .flag_c  (flag_c),
    .flag_z  (flag_z),
    .n_load  (n_load),
    .bus_oe  (bus_oe),
    .pc_inc  (pc_inc),
    .alu_sub (alu_sub),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  function automatic cyc_t mk(input logic [4:0] oe, input logic [7:0] ld,
                              input logic inc, input logic sub);
    cyc_t c;
    c.oe  = oe;
    c.ld  = ld;
    c.inc = inc;
    c.sub = sub;
    return c;
  endfunction

  // One entry per clock the instruction occupies; ld is the active-high load set.
  task automatic model_build(input logic [3:0] op, input logic fc, input logic fz);
    exp_q.delete();
    exp_q.push_back(mk(5'h01, 8'h01, 1'b1 & 1'b0, 1'b0));
    exp_q.push_back(mk(5'h02, 8'h02, 1'b1, 1'b0));
    case (op)
      4'h0: begin
        exp_q.push_back(mk(5'h04, 8'h01, 1'b0, 1'b0));
        exp_q.push_back(mk(5'h02, 8'h04, 1'b0, 1'b0));
      end
      4'h1, 4'h2: begin
        exp_q.push_back(mk(5'h04, 8'h01, 1'b0, 1'b0));
        exp_q.push_back(mk(5'h02, 8'h08, 1'b0, 1'b0));
        exp_q.push_back(mk(5'h10, 8'h44, 1'b0, op == 4'h2));
      end
      4'h4: begin
        exp_q.push_back(mk(5'h04, 8'h01, 1'b0, 1'b0));
        exp_q.push_back(mk(5'h08, 8'h20, 1'b0, 1'b0));
      end
      4'h5: exp_q.push_back(mk(5'h04, 8'h04, 1'b0, 1'b0));
      4'h6: exp_q.push_back(mk(5'h04, 8'h80, 1'b0, 1'b0));
      4'h7: exp_q.push_back(mk(5'h04, fc ? 8'h80 : 8'h00, 1'b0, 1'b0));
      4'h8: exp_q.push_back(mk(5'h04, fz ? 8'h80 : 8'h00, 1'b0, 1'b0));
      4'hE: exp_q.push_back(mk(5'h08, 8'h10, 1'b0, 1'b0));
      default: exp_q.push_back(mk(5'h00, 8'h00, 1'b0, 1'b0));
    endcase
  endtask

  // Entered at posedge+1 with the sequencer at T1; leaves at posedge+1 after the last step.
  task automatic test_instr(input logic [3:0] op, input logic fc, input logic fz,
                            input int stall_at, input int stall_len);
    int   obs_ld[8];
    int   exp_ld[8];
    cyc_t e;
    opcode  = op;
    flag_c  = fc;
    flag_z  = fz;
    step_en = 1'b1;
    model_build(op, fc, fz);
    for (int b = 0; b < 8; b++) begin
      obs_ld[b] = 0;
      exp_ld[b] = 0;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      if (i == stall_at) begin
        step_en = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          n_cmp++;
          if ({n_load, bus_oe, pc_inc, alu_sub} !== {8'hFF, 5'h00, 2'b00}) begin
            n_err++;
            $display("FAIL stall op=%h step=%0d: got n_load=%h oe=%h inc=%b sub=%b, want FF/00/0/0",
                     op, i, n_load, bus_oe, pc_inc, alu_sub);
          end
          for (int b = 0; b < 8; b++) if (n_load[b] === 1'b0) obs_ld[b]++;
          @(posedge clk);
          #1;
        end
        step_en = 1'b1;
      end
      @(negedge clk);
      n_cmp++;
      if (n_load !== ~e.ld) begin
        n_err++;
        $display("FAIL n_load op=%h step=%0d: got %h want %h", op, i, n_load, ~e.ld);
      end
      n_cmp++;
      if (bus_oe !== e.oe) begin
        n_err++;
        $display("FAIL bus_oe op=%h step=%0d: got %h want %h", op, i, bus_oe, e.oe);
      end
      n_cmp++;
      if (pc_inc !== e.inc) begin
        n_err++;
        $display("FAIL pc_inc op=%h step=%0d: got %b want %b", op, i, pc_inc, e.inc);
      end
      n_cmp++;
      if (alu_sub !== e.sub) begin
        n_err++;
        $display("FAIL alu_sub op=%h step=%0d: got %b want %b", op, i, alu_sub, e.sub);
      end
      n_cmp++;
      if ($countones(bus_oe) > 1) begin
        n_err++;
        $display("FAIL onehot op=%h step=%0d: got oe=%h want at most one bit", op, i, bus_oe);
      end
      n_cmp++;
      if (halted !== 1'b0) begin
        n_err++;
        $display("FAIL halted_run op=%h step=%0d: got %b want 0", op, i, halted);
      end
      for (int b = 0; b < 8; b++) begin
        if (n_load[b] === 1'b0) obs_ld[b]++;
        if (e.ld[b]) exp_ld[b]++;
      end
      @(posedge clk);
      #1;
    end
    for (int b = 0; b < 8; b++) begin
      n_cmp++;
      if (obs_ld[b] != exp_ld[b]) begin
        n_err++;
        $display("FAIL load_count op=%h bit=%0d: got %0d want %0d", op, b, obs_ld[b], exp_ld[b]);
      end
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    step_en = 1'b1;
    opcode  = 4'h0;
    flag_c  = 1'b0;
    flag_z  = 1'b0;
    #1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({n_load, bus_oe, pc_inc, alu_sub} !== {8'hFF, 5'h00, 2'b00}) begin
      n_err++;
      $display("FAIL reset_outputs: got n_load=%h oe=%h inc=%b sub=%b, want FF/00/0/0",
               n_load, bus_oe, pc_inc, alu_sub);
    end
    n_cmp++;
    if (halted !== 1'b0) begin
      n_err++;
      $display("FAIL reset_halted: got %b want 0", halted);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_fetch_exec();
    test_instr(4'h0, 1'b0, 1'b0, -1, 0);
    test_instr(4'h2, 1'b0, 1'b0, -1, 0);
    test_instr(4'h1, 1'b1, 1'b1, -1, 0);
    test_instr(4'h4, 1'b0, 1'b0, -1, 0);
    test_instr(4'h5, 1'b0, 1'b0, -1, 0);
    test_instr(4'h6, 1'b0, 1'b0, -1, 0);
    test_instr(4'hE, 1'b0, 1'b0, -1, 0);
    test_instr(4'h3, 1'b1, 1'b1, -1, 0);
  endtask

  task automatic test_cond_jump();
    test_instr(4'h7, 1'b0, 1'b1, -1, 0);
    test_instr(4'h7, 1'b1, 1'b0, -1, 0);
    test_instr(4'h8, 1'b1, 1'b0, -1, 0);
    test_instr(4'h8, 1'b0, 1'b1, -1, 0);
  endtask

  task automatic test_stall();
    test_instr(4'h1, 1'b0, 1'b0, 3, 3);
    test_instr(4'h0, 1'b0, 1'b0, 1, 2);
  endtask

  task automatic test_halt();
    test_instr(4'hF, 1'b0, 1'b0, -1, 0);
    for (int k = 0; k < 10; k++) begin
      step_en = 1'($urandom_range(0, 1));
      opcode  = 4'($urandom_range(0, 15));
      @(negedge clk);
      n_cmp++;
      if ({halted, n_load, bus_oe, pc_inc, alu_sub} !== {1'b1, 8'hFF, 5'h00, 2'b00}) begin
        n_err++;
        $display("FAIL halt_hold cyc=%0d: got halted=%b n_load=%h oe=%h inc=%b sub=%b, want 1/FF/00/0/0",
                 k, halted, n_load, bus_oe, pc_inc, alu_sub);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (halted !== 1'b0) begin
      n_err++;
      $display("FAIL halt_clear: got %b want 0", halted);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_instr(4'h0, 1'b0, 1'b0, -1, 0);
  endtask

  task automatic test_async_reset();
    opcode  = 4'h4;
    step_en = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_cmp++;
    if ({n_load, bus_oe} !== {8'hDF, 5'h08}) begin
      n_err++;
      $display("FAIL sta_t4: got n_load=%h oe=%h want DF/08", n_load, bus_oe);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({n_load, bus_oe, pc_inc, alu_sub} !== {8'hFF, 5'h00, 2'b00}) begin
      n_err++;
      $display("FAIL async_rst: got n_load=%h oe=%h inc=%b sub=%b want FF/00/0/0",
               n_load, bus_oe, pc_inc, alu_sub);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_instr(4'h0, 1'b0, 1'b0, -1, 0);
  endtask

  task automatic test_random();
    logic [3:0] op;
    int         sa;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 14));
      sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1;
      test_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 sa, int'($urandom_range(1, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_fetch_exec();
    test_cond_jump();
    test_stall();
    test_async_reset();
    test_random();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
Microcoded control sequencer for the 8-bit bus computer built around the `register` instances (A, B, IR, MAR, OUT, PC).
- Steps a 5-state T-counter through fetch and execute.
- Drives the active-low load strobes, bus output enables, PC increment and ALU subtract line.
- Sits between the instruction register and the datapath, and owns halt and single-step gating.

Parameters:
STEP_W, 3, width of the internal T-state counter; must hold values 0..4.
HLT_OPCODE, 4'hF, opcode that halts the machine.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
step_en  input  1  advance enable; when low, the sequencer stalls.
opcode  input  4  upper nibble of IR; sampled in T3..T5.
flag_c  input  1  registered ALU carry flag.
flag_z  input  1  registered ALU zero flag.
n_load  output  8  active-low load strobes. Bit map: 0 MAR, 1 IR, 2 A, 3 B, 4 OUT, 5 RAM write, 6 FLAGS, 7 PC (jump).
bus_oe  output  5  active-high bus drivers. Bit map: 0 PC, 1 RAM, 2 IR low nibble, 3 A, 4 ALU.
pc_inc  output  1  PC count enable.
alu_sub  output  1  ALU subtract select.
halted  output  1  high once HLT has executed.

Behaviour:
- State: step (T1..T5, encoded 0..4) and halted. Control outputs are combinational decode of step, opcode and flags.
- Reset (async, while rst=1): step=T1, halted=0; n_load=8'hFF, bus_oe=0, pc_inc=0, alu_sub=0.
- Output gating: when step_en=0 or halted=1, all outputs are forced inactive (n_load=FF, bus_oe=0, pc_inc=0, alu_sub=0) and step holds.
- Fetch steps:
  - T1: bus_oe[0], n_load[0]=0.
  - T2: bus_oe[1], n_load[1]=0, pc_inc=1.
- Execute steps (T3, T4, T5; "end" = next step is T1):
  - 0 LDA: T3 oe[2]+MAR; T4 oe[1]+A, end.
  - 1 ADD: T3 oe[2]+MAR; T4 oe[1]+B; T5 oe[4]+A+FLAGS, end.
  - 2 SUB: same as ADD, with alu_sub=1 in T5.
  - 4 STA: T3 oe[2]+MAR; T4 oe[3]+RAM, end.
  - 5 LDI: T3 oe[2]+A, end.
  - 6 JMP: T3 oe[2]+PC, end.
  - 7 JC: T3 oe[2], with PC load only if flag_c=1; end either way.
  - 8 JZ: as JC, using flag_z.
  - E OUT: T3 oe[3]+OUT, end.
  - HLT_OPCODE: T3 no strobes; halted<=1 at the T3 edge; step<=T1.
  - Any other opcode: T3 empty, end (NOP).
- Cycle cost per instruction: LDA/STA 4; ADD/SUB 5; all others 3.
- Invariant: at most one bus_oe bit is high in any cycle.
- pc_inc asserts only in T2.
- Flags are sampled combinationally in T3 only.
- step never exceeds T5; out-of-range encodings force step<=T1.
- step_en dropped mid-instruction: the sequence resumes at the same step with identical outputs. No strobe repeats, because outputs stay gated during the stall.
- halted clears only via rst. While halted, step stays T1 regardless of step_en.
- rst mid-instruction: outputs go inactive immediately (asynchronous); the next instruction starts at T1 after rst falls.

Test Plan:
- Reset then release, step_en=1, opcode=0 (LDA) → T1: bus_oe=01, n_load=FE; T2: bus_oe=02, n_load=FD, pc_inc=1; T3: bus_oe=04, n_load=FE; T4: bus_oe=02, n_load=FB; T1 follows.
- opcode=2 (SUB) → T5 shows bus_oe=10, n_load=BB, alu_sub=1; 5 cycles total; one-hot bus_oe in every cycle.
- opcode=7 with flag_c=0, then with flag_c=1 → T3 n_load=FF vs 7F, bus_oe=04 in both; 3 cycles each.
- opcode=F → halted=1 after T3; next 10 cycles all outputs inactive, step frozen; assert rst → halted=0, fetch restarts.
- ADD with step_en low for 3 cycles after T3 → outputs inactive during the stall; T4 resumes with bus_oe=02, n_load=F7; exactly one B load.
- rst pulsed asynchronously mid-T4 of STA → n_load=FF and bus_oe=0 within the same cycle; after release, T1 outputs appear.
